// File: rtl/compress_block_if.sv
// Block-level bus between the compressor top level and one compress_block instance.
interface compress_block_if;
  logic              start_block;
  logic [7:0]        pixel_block [8][8];
  logic [15:0]       quant_recip [8][8];
  logic signed [8:0] quantized_coeffs [8][8];
  logic              busy;
  logic              block_done;

  // start_block is a level sampled only in IDLE (no ready); block_done is a one-cycle pulse with no back-pressure.
  modport master (output start_block, pixel_block, quant_recip,
                  input  quantized_coeffs, busy, block_done);
  modport slave  (input  start_block, pixel_block, quant_recip,
                  output quantized_coeffs, busy, block_done);
endinterface

// File: rtl/compress_block.sv
// 8x8 forward path: level shift, separable DCT-II (row pass then column pass),
// reciprocal quantization with round-half-up, saturation to 9-bit signed.
module compress_block (
  input  logic              clk,
  input  logic              rst,
  compress_block_if.slave   bus,
  output logic [2:0]        dbg_state
);
  localparam int COS_FRAC   = 8;
  localparam int RECIP_FRAC = 15;
  localparam int SH         = 2 * COS_FRAC + RECIP_FRAC;
  localparam logic signed [51:0] HALF = 52'sd1 <<< (SH - 1);

  // C[u][x], u-major, scaled by 2^COS_FRAC.
  localparam logic signed [9:0] COS_TAB [64] = '{
    10'sd91,  10'sd91,   10'sd91,   10'sd91,   10'sd91,   10'sd91,   10'sd91,   10'sd91,
    10'sd126, 10'sd106,  10'sd71,   10'sd25,   -10'sd25,  -10'sd71,  -10'sd106, -10'sd126,
    10'sd118, 10'sd49,   -10'sd49,  -10'sd118, -10'sd118, -10'sd49,  10'sd49,   10'sd118,
    10'sd106, -10'sd25,  -10'sd126, -10'sd71,  10'sd71,   10'sd126,  10'sd25,   -10'sd106,
    10'sd91,  -10'sd91,  -10'sd91,  10'sd91,   10'sd91,   -10'sd91,  -10'sd91,  10'sd91,
    10'sd71,  -10'sd126, 10'sd25,   10'sd106,  -10'sd106, -10'sd25,  10'sd126,  -10'sd71,
    10'sd49,  -10'sd118, 10'sd118,  -10'sd49,  -10'sd49,  10'sd118,  -10'sd118, 10'sd49,
    10'sd25,  -10'sd71,  10'sd106,  -10'sd126, 10'sd126,  -10'sd106, 10'sd71,   -10'sd25
  };

  typedef enum logic [2:0] {IDLE = 3'd0, ROW = 3'd1, COL = 3'd2, TAIL = 3'd3, DONE = 3'd4} state_t;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [7:0]         pix_q [8][8], pix_d [8][8];
  logic [15:0]        recip_q [8][8], recip_d [8][8];
  logic signed [21:0] r_q [8][8], r_d [8][8];
  logic signed [34:0] f_q, f_d;
  logic [5:0]         f_idx_q, f_idx_d;
  logic               f_vld_q, f_vld_d;
  logic signed [8:0]  coef_q [8][8], coef_d [8][8];

  logic [2:0]         hi, lo;
  logic signed [21:0] row_dot;
  logic signed [34:0] col_dot;
  logic signed [51:0] prod, q_full;
  logic signed [8:0]  q_sat;

  // Datapath: hi/lo are (y,u) in ROW and (v,u) in COL; quantizer works on the previous COL result.
  always_comb begin
    hi      = cnt_q[5:3];
    lo      = cnt_q[2:0];
    row_dot = '0;
    col_dot = '0;
    for (int x = 0; x < 8; x++) begin
      row_dot = row_dot
              + 22'($signed({1'b0, pix_q[hi][3'(x)]}) - 9'sd128) * 22'(COS_TAB[{lo, 3'(x)}]);
    end
    for (int y = 0; y < 8; y++) begin
      col_dot = col_dot + 35'(COS_TAB[{hi, 3'(y)}]) * 35'(r_q[3'(y)][lo]);
    end
    prod   = 52'(f_q) * 52'($signed({1'b0, recip_q[f_idx_q[5:3]][f_idx_q[2:0]]}));
    q_full = (prod + HALF) >>> SH;
    if (q_full > 52'sd255)       q_sat = 9'h0FF;
    else if (q_full < -52'sd256) q_sat = 9'h100;
    else                         q_sat = q_full[8:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    recip_d = recip_q;
    r_d     = r_q;
    f_d     = f_q;
    f_idx_d = f_idx_q;
    f_vld_d = 1'b0;
    coef_d  = coef_q;
    if (f_vld_q) coef_d[f_idx_q[5:3]][f_idx_q[2:0]] = q_sat;
    case (state_q)
      IDLE: if (bus.start_block) begin
        pix_d   = bus.pixel_block;
        recip_d = bus.quant_recip;
        cnt_d   = '0;
        state_d = ROW;
      end
      ROW: begin
        r_d[hi][lo] = row_dot;
        cnt_d       = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = COL;
      end
      COL: begin
        f_d     = col_dot;
        f_idx_d = cnt_q;
        f_vld_d = 1'b1;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = TAIL;
      end
      TAIL:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pix_q   <= '{default: '0};
      recip_q <= '{default: '0};
      r_q     <= '{default: '0};
      f_q     <= '0;
      f_idx_q <= '0;
      f_vld_q <= 1'b0;
      coef_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      recip_q <= recip_d;
      r_q     <= r_d;
      f_q     <= f_d;
      f_idx_q <= f_idx_d;
      f_vld_q <= f_vld_d;
      coef_q  <= coef_d;
    end
  end

  assign bus.quantized_coeffs = coef_q;
  assign bus.busy             = (state_q == ROW) || (state_q == COL) || (state_q == TAIL);
  assign bus.block_done       = (state_q == DONE);
  assign dbg_state            = state_q;
endmodule
